// File: rtl/ppu_scroll_v_unit.sv
// Registered PPU "loopy" v-address update unit.
// Applies render increments and copies, CPU loads and CPU $2007 increments.
module ppu_scroll_v_unit #(
  parameter int COARSE_X_BITS = 5,
  parameter int COARSE_Y_BITS = 5,
  parameter int FINE_Y_BITS   = 3,
  parameter int COARSE_Y_LAST = 29,
  localparam int W = COARSE_X_BITS + COARSE_Y_BITS + 2 + FINE_Y_BITS
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [W-1:0] i_t,
  input  logic         i_load,
  input  logic [W-1:0] i_load_value,
  input  logic         i_inc_x,
  input  logic         i_inc_y,
  input  logic         i_copy_h,
  input  logic         i_copy_v,
  input  logic         i_inc_addr,
  input  logic         i_inc_32,
  output logic [W-1:0] o_v,
  output logic         o_wrap_x,
  output logic         o_wrap_y
);

  localparam int CY_LO = COARSE_X_BITS;
  localparam int NTX   = COARSE_X_BITS + COARSE_Y_BITS;
  localparam int NTY   = NTX + 1;
  localparam int FY_LO = NTY + 1;

  localparam logic [COARSE_Y_BITS-1:0] CY_LAST = COARSE_Y_LAST[COARSE_Y_BITS-1:0];
  localparam logic [W-1:0] STEP_1  = W'(1);
  localparam logic [W-1:0] STEP_32 = W'(1) << COARSE_X_BITS;

  logic [COARSE_X_BITS-1:0] cx, cx_n;
  logic [COARSE_Y_BITS-1:0] cy, cy_n;
  logic [FINE_Y_BITS-1:0]   fy, fy_n;
  logic                     ntx, ntx_n, nty, nty_n;
  logic [W-1:0]             v_next;
  logic                     wrap_x_n, wrap_y_n;
  logic                     render;

  assign cx  = o_v[COARSE_X_BITS-1:0];
  assign cy  = o_v[NTX-1:CY_LO];
  assign ntx = o_v[NTX];
  assign nty = o_v[NTY];
  assign fy  = o_v[W-1:FY_LO];

  assign render = i_inc_x | i_inc_y | i_copy_h | i_copy_v;

  // Horizontal and vertical fields are updated independently so that
  // several render ops in one cycle compose; copies beat increments.
  always_comb begin
    cx_n     = cx;
    ntx_n    = ntx;
    cy_n     = cy;
    nty_n    = nty;
    fy_n     = fy;
    wrap_x_n = 1'b0;
    wrap_y_n = 1'b0;
    v_next   = o_v;

    if (i_copy_h) begin
      cx_n  = i_t[COARSE_X_BITS-1:0];
      ntx_n = i_t[NTX];
    end else if (i_inc_x) begin
      if (&cx) begin
        cx_n     = '0;
        ntx_n    = ~ntx;
        wrap_x_n = 1'b1;
      end else begin
        cx_n = cx + COARSE_X_BITS'(1);
      end
    end

    if (i_copy_v) begin
      cy_n  = i_t[NTX-1:CY_LO];
      nty_n = i_t[NTY];
      fy_n  = i_t[W-1:FY_LO];
    end else if (i_inc_y) begin
      if (!(&fy)) begin
        fy_n = fy + FINE_Y_BITS'(1);
      end else begin
        fy_n = '0;
        if (cy == CY_LAST) begin
          cy_n     = '0;
          nty_n    = ~nty;
          wrap_y_n = 1'b1;
        end else if (&cy) begin
          cy_n = '0;
        end else begin
          cy_n = cy + COARSE_Y_BITS'(1);
        end
      end
    end

    if (i_load) begin
      v_next   = i_load_value;
      wrap_x_n = 1'b0;
      wrap_y_n = 1'b0;
    end else if (render) begin
      v_next = {fy_n, nty_n, ntx_n, cy_n, cx_n};
    end else if (i_inc_addr) begin
      v_next = o_v + (i_inc_32 ? STEP_32 : STEP_1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_v      <= '0;
      o_wrap_x <= 1'b0;
      o_wrap_y <= 1'b0;
    end else begin
      o_v      <= v_next;
      o_wrap_x <= wrap_x_n;
      o_wrap_y <= wrap_y_n;
    end
  end

endmodule

// File: tb/tb_ppu_scroll_v_unit.sv
// Self-checking bench for ppu_scroll_v_unit: directed cases plus random
// commands compared against a field-arithmetic reference model.
module tb_ppu_scroll_v_unit;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [14:0] i_t;
  logic        i_load;
  logic [14:0] i_load_value;
  logic        i_inc_x, i_inc_y, i_copy_h, i_copy_v, i_inc_addr, i_inc_32;
  logic [14:0] o_v;
  logic        o_wrap_x, o_wrap_y;

  int evaluated = 0;
  int failures  = 0;
  int mdl_v     = 0;
  bit mdl_wx    = 0;
  bit mdl_wy    = 0;

  ppu_scroll_v_unit dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_t(i_t), .i_load(i_load),
    .i_load_value(i_load_value), .i_inc_x(i_inc_x), .i_inc_y(i_inc_y),
    .i_copy_h(i_copy_h), .i_copy_v(i_copy_v), .i_inc_addr(i_inc_addr),
    .i_inc_32(i_inc_32), .o_v(o_v), .o_wrap_x(o_wrap_x), .o_wrap_y(o_wrap_y)
  );

  always #5 i_clk = ~i_clk;

  // Reference: decompose v into fields with plain arithmetic, apply the rules, recompose.
  function automatic void model(input int v, input int t, input bit ld, input int lv,
                                input bit ix, input bit iy, input bit ch, input bit cv,
                                input bit ia, input bit i32,
                                output int nv, output bit wx, output bit wy);
    int cx  = v % 32;
    int cy  = (v / 32) % 32;
    int ntx = (v / 1024) % 2;
    int nty = (v / 2048) % 2;
    int fy  = v / 4096;
    wx = 0;
    wy = 0;
    if (ld) begin
      nv = lv;
    end else if (ix || iy || ch || cv) begin
      if (ch) begin
        cx  = t % 32;
        ntx = (t / 1024) % 2;
      end else if (ix) begin
        if (cx == 31) begin cx = 0; ntx = 1 - ntx; wx = 1; end
        else cx = cx + 1;
      end
      if (cv) begin
        cy  = (t / 32) % 32;
        nty = (t / 2048) % 2;
        fy  = t / 4096;
      end else if (iy) begin
        if (fy < 7) fy = fy + 1;
        else begin
          fy = 0;
          if (cy == 29) begin cy = 0; nty = 1 - nty; wy = 1; end
          else if (cy == 31) cy = 0;
          else cy = cy + 1;
        end
      end
      nv = cx + cy * 32 + ntx * 1024 + nty * 2048 + fy * 4096;
    end else if (ia) begin
      nv = (v + (i32 ? 32 : 1)) % 32768;
    end else begin
      nv = v;
    end
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    evaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".v"}, int'(o_v), mdl_v);
    checkOutput({tag, ".wrap_x"}, int'(o_wrap_x), int'(mdl_wx));
    checkOutput({tag, ".wrap_y"}, int'(o_wrap_y), int'(mdl_wy));
  endtask

  // Drive one cycle of commands, advance the model, then sample 1ns after the edge.
  task automatic applyStimulus(input string tag, input bit ld, input int lv, input int t,
                               input bit ix, input bit iy, input bit ch, input bit cv,
                               input bit ia, input bit i32);
    int nv;
    bit wx, wy;
    i_load = ld; i_load_value = 15'(lv); i_t = 15'(t);
    i_inc_x = ix; i_inc_y = iy; i_copy_h = ch; i_copy_v = cv;
    i_inc_addr = ia; i_inc_32 = i32;
    model(mdl_v, t, ld, lv, ix, iy, ch, cv, ia, i32, nv, wx, wy);
    @(posedge i_clk);
    #1;
    mdl_v = nv; mdl_wx = wx; mdl_wy = wy;
    checkAll(tag);
  endtask

  task automatic loadV(input int value);
    applyStimulus("load", 1, value, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle();
    applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_load = 0; i_load_value = '0; i_t = '0;
    i_inc_x = 0; i_inc_y = 0; i_copy_h = 0; i_copy_v = 0; i_inc_addr = 0; i_inc_32 = 0;
    #2;
    checkAll("reset");
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Coarse X wrap and plain increment
    loadV(16'h001F);
    applyStimulus("incx_wrap", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("incx_wrap.lit", int'(o_v), 16'h0400);
    checkOutput("incx_wrap.pulse", int'(o_wrap_x), 1);
    applyStimulus("incx_plain", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("incx_plain.lit", int'(o_v), 16'h0401);
    idle();

    // Y increment at last visible row and in attribute area
    loadV(16'h73A0);
    applyStimulus("incy_wrap", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("incy_wrap.lit", int'(o_v), 16'h0800);
    checkOutput("incy_wrap.pulse", int'(o_wrap_y), 1);
    loadV(16'h73E0);
    applyStimulus("incy_attr", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("incy_attr.lit", int'(o_v), 16'h0000);

    // copy_h beats inc_x horizontally while inc_y still applies
    loadV(16'h001F);
    applyStimulus("mixed", 0, 0, 16'h7BFF, 1, 1, 1, 0, 0, 0);
    checkOutput("mixed.lit", int'(o_v), 16'h101F);

    // Address increments wrap modulo 2^15; render op suppresses them
    loadV(16'h7FFF);
    applyStimulus("addr32", 0, 0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("addr32.lit", int'(o_v), 16'h001F);
    loadV(16'h7FFF);
    applyStimulus("addr1", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("addr1.lit", int'(o_v), 16'h0000);
    applyStimulus("addr_vs_incx", 0, 0, 0, 1, 0, 0, 0, 1, 1);
    checkOutput("addr_vs_incx.lit", int'(o_v), 16'h0001);

    // Load beats everything and suppresses pulses
    loadV(16'h73BF);
    applyStimulus("load_prio", 1, 16'h2108, 0, 1, 1, 0, 0, 1, 0);
    checkOutput("load_prio.lit", int'(o_v), 16'h2108);

    // Copies never pulse even when nametable bits change
    loadV(16'h0000);
    applyStimulus("copy_hv", 0, 0, 16'h7FFF, 0, 0, 1, 1, 0, 0);

    // Asynchronous reset while a wrap pulse is high
    loadV(16'h001F);
    applyStimulus("pre_reset", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    #2;
    i_reset_n = 1'b0;
    #1;
    mdl_v = 0; mdl_wx = 0; mdl_wy = 0;
    checkAll("async_reset");
    @(posedge i_clk);
    #1;
    checkAll("held_reset");
    @(negedge i_clk);
    i_reset_n = 1'b1;
    applyStimulus("resume", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("resume.lit", int'(o_v), 16'h0001);

    // Random commands: loads kept rare so render/addr paths dominate
    for (int i = 0; i < 400; i++) begin
      applyStimulus("random",
                    ($urandom_range(0, 9) == 0), int'($urandom_range(0, 32767)),
                    int'($urandom_range(0, 32767)),
                    1'($urandom), 1'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule
